// File: rtl/fphub_mult_sched_pkg.sv
// Shared types and special-value constants for the HUB floating-point multiplier
// sequencer and its operand classifier.
package fphub_pkg;

    typedef enum logic [2:0] {
        SC_NONE     = 3'd0,
        SC_POS_INF  = 3'd1,
        SC_NEG_INF  = 3'd2,
        SC_POS_ZERO = 3'd3,
        SC_NEG_ZERO = 3'd4,
        SC_POS_ONE  = 3'd5,
        SC_NEG_ONE  = 3'd6
    } special_case_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    // Magnitudes are returned right-aligned in 64 bits; callers slice [e+m-1:0].
    function automatic logic [63:0] hub_inf(input int e, input int m);
        return (64'd1 << (e + m)) - 64'd1;
    endfunction

    function automatic logic [63:0] hub_zero(input int e, input int m);
        return 64'd0 << (e + m);
    endfunction

    function automatic logic [63:0] hub_one(input int e, input int m);
        return 64'd1 << (e + m - 1);
    endfunction

endpackage

// File: rtl/fphub_mult_sched_detector.sv
// Classifies two HUB operands into special-case codes (inf, zero, one, none),
// each with its sign folded into the code.
module special_cases_detector
    import fphub_pkg::*;
#(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic [E+M:0] x,
    input  logic [E+M:0] y,
    output logic [2:0]   case_x,
    output logic [2:0]   case_y
);

    localparam logic [63:0]    INF64    = hub_inf(E, M);
    localparam logic [63:0]    ZERO64   = hub_zero(E, M);
    localparam logic [63:0]    ONE64    = hub_one(E, M);
    localparam logic [E+M-1:0] MAG_INF  = INF64[E+M-1:0];
    localparam logic [E+M-1:0] MAG_ZERO = ZERO64[E+M-1:0];
    localparam logic [E+M-1:0] MAG_ONE  = ONE64[E+M-1:0];

    logic [E+M:0] op   [2];
    logic [2:0]   code [2];

    assign op[0] = x;
    assign op[1] = y;

    for (genvar gi = 0; gi < 2; gi++) begin : g_cls
        logic         sgn;
        logic [E+M-1:0] mag;

        assign sgn = op[gi][E+M];
        assign mag = op[gi][E+M-1:0];
        assign code[gi] = (mag == MAG_INF)  ? (sgn ? SC_NEG_INF  : SC_POS_INF)  :
                          (mag == MAG_ZERO) ? (sgn ? SC_NEG_ZERO : SC_POS_ZERO) :
                          (mag == MAG_ONE)  ? (sgn ? SC_NEG_ONE  : SC_POS_ONE)  :
                                              SC_NONE;
    end

    assign case_x = code[0];
    assign case_y = code[1];

endmodule

// File: rtl/fphub_mult_sched.sv
// Sequencer for the HUB multiplier: resolves special-case products locally and
// hands all other operand pairs to the multi-cycle core, with a hang timeout.
module fphub_mult_sched
    import fphub_pkg::*;
#(
    parameter int M       = 23,
    parameter int E       = 8,
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [E+M:0] X,
    input  logic [E+M:0] Y,
    output logic         mul_start,
    output logic [E+M:0] mul_x,
    output logic [E+M:0] mul_y,
    input  logic         mul_done,
    input  logic [E+M:0] mul_z,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [E+M:0] Z,
    output logic         out_special,
    output logic         out_invalid,
    output logic         out_timeout,
    output logic [15:0]  special_cnt
);

    localparam int W  = E + M + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [63:0]    INF64    = hub_inf(E, M);
    localparam logic [63:0]    ZERO64   = hub_zero(E, M);
    localparam logic [E+M-1:0] MAG_INF  = INF64[E+M-1:0];
    localparam logic [E+M-1:0] MAG_ZERO = ZERO64[E+M-1:0];

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_inc;
    logic [W-1:0]    mul_x_reg, mul_y_reg, z_reg;
    logic            special_reg, invalid_reg, timeout_reg;
    logic [15:0]     special_cnt_reg;

    logic [2:0]      case_x, case_y;
    logic            x_inf, y_inf, x_zero, y_zero, x_one, y_one;
    logic            byp, byp_invalid, sign_xy, timeout_hit;
    logic [W-1:0]    byp_z;

    special_cases_detector #(.M(M), .E(E)) u_detect (
        .x      (X),
        .y      (Y),
        .case_x (case_x),
        .case_y (case_y)
    );

    assign x_inf  = (case_x == SC_POS_INF)  || (case_x == SC_NEG_INF);
    assign y_inf  = (case_y == SC_POS_INF)  || (case_y == SC_NEG_INF);
    assign x_zero = (case_x == SC_POS_ZERO) || (case_x == SC_NEG_ZERO);
    assign y_zero = (case_y == SC_POS_ZERO) || (case_y == SC_NEG_ZERO);
    assign x_one  = (case_x == SC_POS_ONE)  || (case_x == SC_NEG_ONE);
    assign y_one  = (case_y == SC_POS_ONE)  || (case_y == SC_NEG_ONE);
    assign sign_xy = X[W-1] ^ Y[W-1];

    // Ordered so that inf*0 is caught before the plain inf/zero rules.
    always_comb begin
        byp         = 1'b1;
        byp_invalid = 1'b0;
        byp_z       = '0;
        if ((x_inf && y_zero) || (x_zero && y_inf)) begin
            byp_z       = {1'b0, MAG_INF};
            byp_invalid = 1'b1;
        end else if (x_inf || y_inf) begin
            byp_z = {sign_xy, MAG_INF};
        end else if (x_zero || y_zero) begin
            byp_z = {sign_xy, MAG_ZERO};
        end else if (x_one) begin
            byp_z = {sign_xy, Y[W-2:0]};
        end else if (y_one) begin
            byp_z = {sign_xy, X[W-2:0]};
        end else begin
            byp = 1'b0;
        end
    end

    // A done pulse in the boundary cycle takes precedence over the timeout.
    assign cnt_inc     = cnt_reg + CW'(1);
    assign timeout_hit = (state_reg == ST_WAIT) && !mul_done && (cnt_inc == CW'(TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (in_valid) state_next = byp ? ST_HOLD : ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (mul_done || timeout_hit) state_next = ST_HOLD;
            ST_HOLD:  if (out_ready) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg         <= '0;
            mul_x_reg       <= '0;
            mul_y_reg       <= '0;
            z_reg           <= '0;
            special_reg     <= 1'b0;
            invalid_reg     <= 1'b0;
            timeout_reg     <= 1'b0;
            special_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: if (in_valid) begin
                    mul_x_reg   <= X;
                    mul_y_reg   <= Y;
                    z_reg       <= byp_z;
                    special_reg <= byp;
                    invalid_reg <= byp_invalid;
                    timeout_reg <= 1'b0;
                end
                ST_ISSUE: cnt_reg <= '0;
                ST_WAIT: begin
                    cnt_reg <= cnt_inc;
                    if (mul_done) begin
                        z_reg <= mul_z;
                    end else if (timeout_hit) begin
                        z_reg       <= '0;
                        timeout_reg <= 1'b1;
                    end
                end
                ST_HOLD: if (out_ready && special_reg && (special_cnt_reg != 16'hFFFF)) begin
                    special_cnt_reg <= special_cnt_reg + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_reg == ST_IDLE);
    assign mul_start   = (state_reg == ST_ISSUE);
    assign out_valid   = (state_reg == ST_HOLD);
    assign mul_x       = mul_x_reg;
    assign mul_y       = mul_y_reg;
    assign Z           = z_reg;
    assign out_special = special_reg;
    assign out_invalid = invalid_reg;
    assign out_timeout = timeout_reg;
    assign special_cnt = special_cnt_reg;

endmodule

// File: tb/tb_fphub_mult_sched.sv
// Directed bench for fphub_mult_sched: bypass products, core path with a stub
// core, backpressure, timeout and reset during an outstanding core operation.
module tb_fphub_mult_sched;

    localparam int M       = 23;
    localparam int E       = 8;
    localparam int TIMEOUT = 16;
    localparam int W       = E + M + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] X = '0;
    logic [W-1:0] Y = '0;
    logic         mul_start;
    logic [W-1:0] mul_x, mul_y;
    logic         mul_done;
    logic [W-1:0] mul_z = 32'h12345678;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Z;
    logic         out_special, out_invalid, out_timeout;
    logic [15:0]  special_cnt;

    logic stub_done  = 1'b0;
    logic stray_done = 1'b0;
    assign mul_done = stub_done | stray_done;

    fphub_mult_sched #(.M(M), .E(E), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .X           (X),
        .Y           (Y),
        .mul_start   (mul_start),
        .mul_x       (mul_x),
        .mul_y       (mul_y),
        .mul_done    (mul_done),
        .mul_z       (mul_z),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .Z           (Z),
        .out_special (out_special),
        .out_invalid (out_invalid),
        .out_timeout (out_timeout),
        .special_cnt (special_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Core stub: answers core_delay cycles after mul_start, never if core_delay < 2.
    int           core_delay = 3;
    int           cd = 0;
    logic         pend = 1'b0;
    int           start_cnt = 0;
    int           start_cyc = 0;
    logic [W-1:0] cap_x = '0;
    logic [W-1:0] cap_y = '0;

    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (rst) begin
            pend <= 1'b0;
        end else if (mul_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
            cap_x     <= mul_x;
            cap_y     <= mul_y;
            if (core_delay >= 2) begin
                pend <= 1'b1;
                cd   <= core_delay - 1;
            end
        end else if (pend) begin
            if (cd == 1) begin
                stub_done <= 1'b1;
                pend      <= 1'b0;
            end else begin
                cd <= cd - 1;
            end
        end
    end

    typedef struct packed {
        logic [W-1:0] z;
        logic         sp;
        logic         inv;
        logic         to;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_special = 0;
    int   acc_cyc = 0;
    int   s0 = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] ez, input logic esp, input logic einv, input logic eto);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_before_send", in_ready, 1);
        X = x;
        Y = y;
        in_valid = 1'b1;
        sb.push_back('{z: ez, sp: esp, inv: einv, to: eto});
        @(posedge clk);
        #1 in_valid = 1'b0;
        acc_cyc = cyc;
        $display("send X=%h Y=%h expect Z=%h sp=%0d inv=%0d to=%0d", x, y, ez, esp, einv, eto);
    endtask

    task automatic collect(input string tag, input int lat, input int hold, input logic stray);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!out_valid && n < TIMEOUT + 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_out_valid"}, out_valid, 1);
        check({tag, "_latency"}, cyc - acc_cyc, lat);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        check({tag, "_z"}, Z, e.z);
        check({tag, "_special"}, out_special, e.sp);
        check({tag, "_invalid"}, out_invalid, e.inv);
        check({tag, "_timeout"}, out_timeout, e.to);
        check({tag, "_in_ready_hold"}, in_ready, 0);
        repeat (hold) begin
            stray_done = stray;
            @(negedge clk);
            stray_done = 1'b0;
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_z"}, Z, e.z);
            check({tag, "_hold_timeout"}, out_timeout, e.to);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        if (e.sp) exp_special++;
        @(negedge clk);
        check({tag, "_in_ready_after"}, in_ready, 1);
        check({tag, "_valid_after"}, out_valid, 0);
        check({tag, "_special_cnt"}, special_cnt, exp_special);
        $display("result %s Z=%h sp=%0d inv=%0d to=%0d cnt=%0d", tag, Z, out_special, out_invalid, out_timeout, special_cnt);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_z", Z, 0);
        check("rst_mul_x", mul_x, 0);
        check("rst_mul_y", mul_y, 0);
        check("rst_flags", {out_special, out_invalid, out_timeout}, 0);
        check("rst_special_cnt", special_cnt, 0);

        // Bypass products: one-cycle latency, no core start.
        s0 = start_cnt;
        send(32'h40000000, 32'h3F123456, 32'h3F123456, 1, 0, 0); collect("plus_one_x", 0, 0, 0);
        send(32'hC0000000, 32'h3F123456, 32'hBF123456, 1, 0, 0); collect("minus_one_x", 0, 0, 0);
        send(32'h3F123456, 32'hC0000000, 32'hBF123456, 1, 0, 0); collect("minus_one_y", 0, 0, 0);
        send(32'h80000000, 32'h3F123456, 32'h80000000, 1, 0, 0); collect("neg_zero", 0, 0, 0);
        send(32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 1, 1, 0); collect("inf_x_zero", 0, 0, 0);
        send(32'h00000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1, 1, 0); collect("zero_x_inf", 0, 0, 0);
        send(32'hFFFFFFFF, 32'h3F000001, 32'hFFFFFFFF, 1, 0, 0); collect("neg_inf", 0, 0, 0);
        check("bypass_no_start", start_cnt - s0, 0);

        // Core path with 5 cycles of backpressure.
        core_delay = 3;
        s0 = start_cnt;
        send(32'h3F800001, 32'h3F800003, 32'h12345678, 0, 0, 0);
        collect("core", 4, 5, 0);
        check("core_start_pulses", start_cnt - s0, 1);
        check("core_start_cycle", start_cyc, acc_cyc);
        check("core_mul_x", cap_x, 32'h3F800001);
        check("core_mul_y", cap_y, 32'h3F800003);
        check("core_mul_x_stable", mul_x, 32'h3F800001);

        // Core never answers; late done pulses during HOLD and IDLE are ignored.
        core_delay = -1;
        s0 = start_cnt;
        send(32'h3F800005, 32'h3F800007, 32'h0, 0, 0, 1);
        collect("timeout", TIMEOUT, 3, 1);
        check("timeout_start_pulses", start_cnt - s0, 1);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        check("stray_idle_valid", out_valid, 0);
        check("stray_idle_ready", in_ready, 1);

        // Reset while waiting on the core.
        send(32'h3F800009, 32'h3F80000B, 32'h0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("wait_in_ready", in_ready, 0);
        check("wait_out_valid", out_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
        exp_special = 0;
        @(negedge clk);
        check("wait_rst_in_ready", in_ready, 1);
        check("wait_rst_special_cnt", special_cnt, 0);
        check("wait_rst_out_valid", out_valid, 0);
        check("wait_rst_z", Z, 0);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        @(negedge clk);
        check("post_rst_stray_valid", out_valid, 0);
        send(32'h3F800009, 32'h40000000, 32'h3F800009, 1, 0, 0);
        collect("post_rst_bypass", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
